axi_arbiter: RTL and testbench



---
 rtl/axi_arbiter_if.sv | 49 ++++
 rtl/axi_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_axi_arbiter.sv | 354 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_arbiter_if.sv
// axi_arbiter_if: bundles the three sides of the arbiter into one interface.
//   fetch port : i_valid, i_addr -> i_rdata, i_ready, i_ovf
//   data port  : d_valid, d_addr, d_wdata, d_wstrb -> d_rdata, d_ready, d_ovf
//   bridge port: m_valid, m_instr, m_addr, m_wdata, m_wstrb <- m_rdata, m_ready
// Modport "slave" is the arbiter's own view; "master" is the view of the
// surrounding core units and bridge that drive the arbiter.
interface axi_arbiter_if #(
  parameter int XLEN = 32
);
  logic              i_valid;
  logic [XLEN-1:0]   i_addr;
  logic [XLEN-1:0]   i_rdata;
  logic              i_ready;
  logic              i_ovf;

  logic              d_valid;
  logic [XLEN-1:0]   d_addr;
  logic [XLEN-1:0]   d_wdata;
  logic [XLEN/8-1:0] d_wstrb;
  logic [XLEN-1:0]   d_rdata;
  logic              d_ready;
  logic              d_ovf;

  logic              m_valid;
  logic              m_instr;
  logic [XLEN-1:0]   m_addr;
  logic [XLEN-1:0]   m_wdata;
  logic [XLEN/8-1:0] m_wstrb;
  logic [XLEN-1:0]   m_rdata;
  logic              m_ready;

  modport slave (
    input  i_valid, i_addr,
    output i_rdata, i_ready, i_ovf,
    input  d_valid, d_addr, d_wdata, d_wstrb,
    output d_rdata, d_ready, d_ovf,
    output m_valid, m_instr, m_addr, m_wdata, m_wstrb,
    input  m_rdata, m_ready
  );

  modport master (
    output i_valid, i_addr,
    input  i_rdata, i_ready, i_ovf,
    output d_valid, d_addr, d_wdata, d_wstrb,
    input  d_rdata, d_ready, d_ovf,
    input  m_valid, m_instr, m_addr, m_wdata, m_wstrb,
    output m_rdata, m_ready
  );
endinterface

// File: rtl/axi_arbiter.sv
// axi_arbiter: shares the single-outstanding bridge port between the fetch
// and data ports. Request pulses are held in one pending slot per port; one
// slot at a time is granted to the bridge and the response is routed back to
// the owning port only. All outputs are registered.
// Ports:
//   clock  rising-edge clock
//   reset  synchronous active-high reset
//   bus    axi_arbiter_if.slave (fetch, data and bridge signal groups)
//
// state | meaning
// IDLE  | no transaction on the bridge; grant a pending slot if any
// BUSY  | one transaction outstanding; wait for m_ready
module axi_arbiter #(
  parameter int XLEN       = 32,
  parameter int FIXED_PRIO = 0
) (
  input  logic          clock,
  input  logic          reset,
  axi_arbiter_if.slave  bus
);
  localparam int SW = XLEN / 8;

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_e;

  state_e          state_q, state_d;
  logic            i_full_q, i_full_d;
  logic [XLEN-1:0] i_addr_q, i_addr_d;
  logic            d_full_q, d_full_d;
  logic [XLEN-1:0] d_addr_q, d_addr_d;
  logic [XLEN-1:0] d_wdata_q, d_wdata_d;
  logic [SW-1:0]   d_wstrb_q, d_wstrb_d;
  logic            last_data_q, last_data_d;

  logic            m_valid_q, m_valid_d;
  logic            m_instr_q, m_instr_d;
  logic [XLEN-1:0] m_addr_q, m_addr_d;
  logic [XLEN-1:0] m_wdata_q, m_wdata_d;
  logic [SW-1:0]   m_wstrb_q, m_wstrb_d;
  logic            i_ready_q, i_ready_d;
  logic [XLEN-1:0] i_rdata_q, i_rdata_d;
  logic            d_ready_q, d_ready_d;
  logic [XLEN-1:0] d_rdata_q, d_rdata_d;
  logic            i_ovf_q, i_ovf_d;
  logic            d_ovf_q, d_ovf_d;

  logic            i_owns, d_owns, pick_data;

  // m_instr_q identifies the owner for the whole BUSY period.
  assign i_owns = (state_q == BUSY) &&  m_instr_q;
  assign d_owns = (state_q == BUSY) && !m_instr_q;

  always_comb begin
    state_d     = state_q;
    i_full_d    = i_full_q;
    i_addr_d    = i_addr_q;
    d_full_d    = d_full_q;
    d_addr_d    = d_addr_q;
    d_wdata_d   = d_wdata_q;
    d_wstrb_d   = d_wstrb_q;
    last_data_d = last_data_q;
    m_valid_d   = 1'b0;
    m_instr_d   = m_instr_q;
    m_addr_d    = m_addr_q;
    m_wdata_d   = m_wdata_q;
    m_wstrb_d   = m_wstrb_q;
    i_ready_d   = 1'b0;
    i_rdata_d   = '0;
    d_ready_d   = 1'b0;
    d_rdata_d   = '0;
    i_ovf_d     = 1'b0;
    d_ovf_d     = 1'b0;
    pick_data   = 1'b0;

    // Capture only sets an empty slot and grant only clears a full one, so
    // the two never touch the same slot in the same cycle.
    if (bus.i_valid) begin
      if (i_full_q || i_owns) begin
        i_ovf_d = 1'b1;
      end else begin
        i_full_d = 1'b1;
        i_addr_d = bus.i_addr;
      end
    end

    if (bus.d_valid) begin
      if (d_full_q || d_owns) begin
        d_ovf_d = 1'b1;
      end else begin
        d_full_d  = 1'b1;
        d_addr_d  = bus.d_addr;
        d_wdata_d = bus.d_wdata;
        d_wstrb_d = bus.d_wstrb;
      end
    end

    case (state_q)
      IDLE: begin
        if (i_full_q || d_full_q) begin
          // Data wins if it is alone, or on a tie when prioritised or when
          // fetch was granted last.
          pick_data = d_full_q &&
                      (!i_full_q || (FIXED_PRIO != 0) || !last_data_q);
          m_valid_d   = 1'b1;
          m_instr_d   = !pick_data;
          m_addr_d    = pick_data ? d_addr_q  : i_addr_q;
          m_wdata_d   = pick_data ? d_wdata_q : '0;
          m_wstrb_d   = pick_data ? d_wstrb_q : '0;
          last_data_d = pick_data;
          if (pick_data) d_full_d = 1'b0;
          else           i_full_d = 1'b0;
          state_d     = BUSY;
        end
      end
      BUSY: begin
        if (bus.m_ready) begin
          if (m_instr_q) begin
            i_ready_d = 1'b1;
            i_rdata_d = bus.m_rdata;
          end else begin
            d_ready_d = 1'b1;
            d_rdata_d = bus.m_rdata;
          end
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      i_full_q    <= 1'b0;
      i_addr_q    <= '0;
      d_full_q    <= 1'b0;
      d_addr_q    <= '0;
      d_wdata_q   <= '0;
      d_wstrb_q   <= '0;
      last_data_q <= 1'b1;
      m_valid_q   <= 1'b0;
      m_instr_q   <= 1'b0;
      m_addr_q    <= '0;
      m_wdata_q   <= '0;
      m_wstrb_q   <= '0;
      i_ready_q   <= 1'b0;
      i_rdata_q   <= '0;
      d_ready_q   <= 1'b0;
      d_rdata_q   <= '0;
      i_ovf_q     <= 1'b0;
      d_ovf_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      i_full_q    <= i_full_d;
      i_addr_q    <= i_addr_d;
      d_full_q    <= d_full_d;
      d_addr_q    <= d_addr_d;
      d_wdata_q   <= d_wdata_d;
      d_wstrb_q   <= d_wstrb_d;
      last_data_q <= last_data_d;
      m_valid_q   <= m_valid_d;
      m_instr_q   <= m_instr_d;
      m_addr_q    <= m_addr_d;
      m_wdata_q   <= m_wdata_d;
      m_wstrb_q   <= m_wstrb_d;
      i_ready_q   <= i_ready_d;
      i_rdata_q   <= i_rdata_d;
      d_ready_q   <= d_ready_d;
      d_rdata_q   <= d_rdata_d;
      i_ovf_q     <= i_ovf_d;
      d_ovf_q     <= d_ovf_d;
    end
  end

  assign bus.m_valid = m_valid_q;
  assign bus.m_instr = m_instr_q;
  assign bus.m_addr  = m_addr_q;
  assign bus.m_wdata = m_wdata_q;
  assign bus.m_wstrb = m_wstrb_q;
  assign bus.i_ready = i_ready_q;
  assign bus.i_rdata = i_rdata_q;
  assign bus.d_ready = d_ready_q;
  assign bus.d_rdata = d_rdata_q;
  assign bus.i_ovf   = i_ovf_q;
  assign bus.d_ovf   = d_ovf_q;
endmodule

// File: tb/tb_axi_arbiter.sv
// Testbench for axi_arbiter: a round-robin instance (bus0) and a fixed-
// priority instance (bus1) share clock and reset.
module tb_axi_arbiter;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int   tests_run = 0;
  int   failed = 0;

  always #5 clock = ~clock;

  axi_arbiter_if #(.XLEN(32)) bus0 ();
  axi_arbiter_if #(.XLEN(32)) bus1 ();

  axi_arbiter #(.XLEN(32), .FIXED_PRIO(0)) dut0 (.clock(clock), .reset(reset), .bus(bus0));
  axi_arbiter #(.XLEN(32), .FIXED_PRIO(1)) dut1 (.clock(clock), .reset(reset), .bus(bus1));

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    bus0.i_valid = 0; bus0.i_addr = 0; bus0.d_valid = 0; bus0.d_addr = 0;
    bus0.d_wdata = 0; bus0.d_wstrb = 0; bus0.m_rdata = 0; bus0.m_ready = 0;
    bus1.i_valid = 0; bus1.i_addr = 0; bus1.d_valid = 0; bus1.d_addr = 0;
    bus1.d_wdata = 0; bus1.d_wstrb = 0; bus1.m_rdata = 0; bus1.m_ready = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1; tick(); reset = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1; tick(); tick();
    tests_run++;
    if ({bus0.m_valid, bus0.m_instr, bus0.m_addr, bus0.m_wdata, bus0.m_wstrb, bus0.i_ready,
         bus0.i_rdata, bus0.d_ready, bus0.d_rdata, bus0.i_ovf, bus0.d_ovf} !== 138'd0) begin
      failed++; $display("FAIL reset_outputs_rr: got m_valid=%b m_addr=%h i_ready=%b d_ready=%b, want all 0",
                         bus0.m_valid, bus0.m_addr, bus0.i_ready, bus0.d_ready);
    end
    tests_run++;
    if ({bus1.m_valid, bus1.m_instr, bus1.m_addr, bus1.m_wdata, bus1.m_wstrb, bus1.i_ready,
         bus1.i_rdata, bus1.d_ready, bus1.d_rdata, bus1.i_ovf, bus1.d_ovf} !== 138'd0) begin
      failed++; $display("FAIL reset_outputs_fp: got m_valid=%b m_addr=%h, want all 0", bus1.m_valid, bus1.m_addr);
    end
    reset = 0; tick();
    // m_ready while idle must be ignored
    bus0.m_ready = 1; bus0.m_rdata = 32'h5555_AAAA; tick();
    bus0.m_ready = 0; bus0.m_rdata = 0;
    tests_run++;
    if ({bus0.i_ready, bus0.d_ready, bus0.i_rdata, bus0.d_rdata} !== 66'd0) begin
      failed++; $display("FAIL idle_mready_ignored: got i_ready=%b d_ready=%b, want 0 0", bus0.i_ready, bus0.d_ready);
    end
    tick();
  endtask

  task automatic test_single_fetch();
    do_reset();
    bus0.i_valid = 1; bus0.i_addr = 32'h100; tick();          // t+1
    bus0.i_valid = 0; bus0.i_addr = 0;
    tests_run++;
    if (bus0.m_valid !== 1'b0) begin
      failed++; $display("FAIL fetch_latency_early: m_valid=%b at t+1, want 0", bus0.m_valid);
    end
    tick();                                                    // t+2
    tests_run++;
    if ({bus0.m_valid, bus0.m_instr, bus0.m_addr, bus0.m_wdata, bus0.m_wstrb} !== {1'b1, 1'b1, 32'h100, 32'h0, 4'h0}) begin
      failed++; $display("FAIL fetch_grant: got v=%b instr=%b addr=%h wdata=%h wstrb=%h, want 1 1 00000100 0 0",
                         bus0.m_valid, bus0.m_instr, bus0.m_addr, bus0.m_wdata, bus0.m_wstrb);
    end
    tick();
    tests_run++;
    if ({bus0.m_valid, bus0.m_instr, bus0.m_addr} !== {1'b0, 1'b1, 32'h100}) begin
      failed++; $display("FAIL fetch_hold: got v=%b instr=%b addr=%h, want 0 1 00000100", bus0.m_valid, bus0.m_instr, bus0.m_addr);
    end
    bus0.m_ready = 1; bus0.m_rdata = 32'hDEAD_BEEF; tick();   // r+1
    bus0.m_ready = 0; bus0.m_rdata = 0;
    tests_run++;
    if ({bus0.i_ready, bus0.i_rdata, bus0.d_ready, bus0.d_rdata} !== {1'b1, 32'hDEAD_BEEF, 1'b0, 32'h0}) begin
      failed++; $display("FAIL fetch_response: got i_ready=%b i_rdata=%h d_ready=%b d_rdata=%h, want 1 deadbeef 0 0",
                         bus0.i_ready, bus0.i_rdata, bus0.d_ready, bus0.d_rdata);
    end
    tick();
    tests_run++;
    if ({bus0.i_ready, bus0.i_rdata, bus0.m_valid} !== {1'b0, 32'h0, 1'b0}) begin
      failed++; $display("FAIL fetch_pulse_end: got i_ready=%b i_rdata=%h m_valid=%b, want 0 0 0", bus0.i_ready, bus0.i_rdata, bus0.m_valid);
    end
  endtask

  task automatic test_data_store();
    do_reset();
    bus0.d_valid = 1; bus0.d_addr = 32'h2000; bus0.d_wdata = 32'h1234_5678; bus0.d_wstrb = 4'hF; tick();
    bus0.d_valid = 0; bus0.d_addr = 0; bus0.d_wdata = 0; bus0.d_wstrb = 0; tick();
    tests_run++;
    if ({bus0.m_valid, bus0.m_instr, bus0.m_addr, bus0.m_wdata, bus0.m_wstrb} !== {1'b1, 1'b0, 32'h2000, 32'h1234_5678, 4'hF}) begin
      failed++; $display("FAIL store_grant: got v=%b instr=%b addr=%h wdata=%h wstrb=%h, want 1 0 00002000 12345678 f",
                         bus0.m_valid, bus0.m_instr, bus0.m_addr, bus0.m_wdata, bus0.m_wstrb);
    end
    tick(); tick();                                            // wait a cycle in BUSY
    tests_run++;
    if ({bus0.m_valid, bus0.m_wdata, bus0.m_wstrb, bus0.d_ready} !== {1'b0, 32'h1234_5678, 4'hF, 1'b0}) begin
      failed++; $display("FAIL store_hold: got v=%b wdata=%h wstrb=%h d_ready=%b, want 0 12345678 f 0",
                         bus0.m_valid, bus0.m_wdata, bus0.m_wstrb, bus0.d_ready);
    end
    bus0.m_ready = 1; bus0.m_rdata = 32'h0BAD_F00D; tick();
    bus0.m_ready = 0; bus0.m_rdata = 0;
    tests_run++;
    if ({bus0.d_ready, bus0.d_rdata, bus0.i_ready, bus0.i_rdata} !== {1'b1, 32'h0BAD_F00D, 1'b0, 32'h0}) begin
      failed++; $display("FAIL store_response: got d_ready=%b d_rdata=%h i_ready=%b i_rdata=%h, want 1 0badf00d 0 0",
                         bus0.d_ready, bus0.d_rdata, bus0.i_ready, bus0.i_rdata);
    end
    tick();
  endtask

  // Phases of requests; each phase lists the grant order it must produce.
  // mask bit0 = fetch, bit1 = data; grant value 1 = data.
  task automatic test_round_robin();
    int  mask [3] = '{3, 1, 3};
    int  ngr  [3] = '{2, 1, 2};
    bit  gr   [3][2] = '{'{1'b0, 1'b1}, '{1'b0, 1'b0}, '{1'b1, 1'b0}};
    logic [31:0] ia, da, dw, rd, ew;
    logic [3:0]  es;
    do_reset();
    for (int ph = 0; ph < 3; ph++) begin
      ia = 32'h1000 + 32'(ph * 16); da = 32'h3000 + 32'(ph * 16); dw = $urandom;
      bus0.i_valid = mask[ph][0]; bus0.i_addr = ia;
      bus0.d_valid = mask[ph][1]; bus0.d_addr = da; bus0.d_wdata = dw; bus0.d_wstrb = 4'h3;
      tick();
      idle_inputs(); tick();
      for (int g = 0; g < ngr[ph]; g++) begin
        ew = gr[ph][g] ? dw : 32'h0;
        es = gr[ph][g] ? 4'h3 : 4'h0;
        tests_run++;
        if ({bus0.m_valid, bus0.m_instr, bus0.m_addr, bus0.m_wdata, bus0.m_wstrb} !==
            {1'b1, !gr[ph][g], (gr[ph][g] ? da : ia), ew, es}) begin
          failed++; $display("FAIL rr_grant ph%0d g%0d: got v=%b instr=%b addr=%h, want 1 %b %h",
                             ph, g, bus0.m_valid, bus0.m_instr, bus0.m_addr, !gr[ph][g], (gr[ph][g] ? da : ia));
        end
        tick();
        rd = $urandom; bus0.m_ready = 1; bus0.m_rdata = rd; tick();
        bus0.m_ready = 0; bus0.m_rdata = 0;
        tests_run++;
        if ({bus0.i_ready, bus0.d_ready, (gr[ph][g] ? bus0.d_rdata : bus0.i_rdata)} !==
            {!gr[ph][g], gr[ph][g], rd}) begin
          failed++; $display("FAIL rr_ready ph%0d g%0d: got i_ready=%b d_ready=%b, want %b %b rdata %h",
                             ph, g, bus0.i_ready, bus0.d_ready, !gr[ph][g], gr[ph][g], rd);
        end
        tick();                                                // r+2: next grant visible here
      end
    end
  endtask

  task automatic test_fixed_prio();
    int  mask [3] = '{3, 2, 3};
    int  ngr  [3] = '{2, 1, 2};
    bit  gr   [3][2] = '{'{1'b1, 1'b0}, '{1'b1, 1'b1}, '{1'b1, 1'b0}};
    logic [31:0] ia, da, rd;
    do_reset();
    for (int ph = 0; ph < 3; ph++) begin
      ia = 32'h5000 + 32'(ph * 16); da = 32'h6000 + 32'(ph * 16);
      bus1.i_valid = mask[ph][0]; bus1.i_addr = ia;
      bus1.d_valid = mask[ph][1]; bus1.d_addr = da; bus1.d_wdata = 32'hA5A5_0000 + 32'(ph); bus1.d_wstrb = 4'h0;
      tick();
      idle_inputs(); tick();
      for (int g = 0; g < ngr[ph]; g++) begin
        tests_run++;
        if ({bus1.m_valid, bus1.m_instr, bus1.m_addr} !== {1'b1, !gr[ph][g], (gr[ph][g] ? da : ia)}) begin
          failed++; $display("FAIL fp_grant ph%0d g%0d: got v=%b instr=%b addr=%h, want 1 %b %h",
                             ph, g, bus1.m_valid, bus1.m_instr, bus1.m_addr, !gr[ph][g], (gr[ph][g] ? da : ia));
        end
        tick();
        rd = $urandom; bus1.m_ready = 1; bus1.m_rdata = rd; tick();
        bus1.m_ready = 0; bus1.m_rdata = 0;
        tests_run++;
        if ({bus1.i_ready, bus1.d_ready} !== {!gr[ph][g], gr[ph][g]}) begin
          failed++; $display("FAIL fp_ready ph%0d g%0d: got i_ready=%b d_ready=%b, want %b %b",
                             ph, g, bus1.i_ready, bus1.d_ready, !gr[ph][g], gr[ph][g]);
        end
        tick();
      end
    end
  endtask

  task automatic test_overflow();
    do_reset();
    bus0.d_valid = 1; bus0.d_addr = 32'hA000; tick();          // t+1
    bus0.d_addr = 32'hB000;                                     // second request, slot full
    tests_run++;
    if (bus0.d_ovf !== 1'b0) begin
      failed++; $display("FAIL ovf_first_accepted: d_ovf=%b, want 0", bus0.d_ovf);
    end
    tick();                                                     // t+2
    bus0.d_valid = 0; bus0.d_addr = 0;
    tests_run++;
    if ({bus0.d_ovf, bus0.m_valid, bus0.m_addr} !== {1'b1, 1'b1, 32'hA000}) begin
      failed++; $display("FAIL ovf_pulse: got d_ovf=%b m_valid=%b m_addr=%h, want 1 1 0000a000",
                         bus0.d_ovf, bus0.m_valid, bus0.m_addr);
    end
    tick();
    tests_run++;
    if ({bus0.d_ovf, bus0.m_valid} !== 2'b00) begin
      failed++; $display("FAIL ovf_one_cycle: got d_ovf=%b m_valid=%b, want 0 0", bus0.d_ovf, bus0.m_valid);
    end
    bus0.m_ready = 1; bus0.m_rdata = 32'h77; tick();            // r+1: d_ready
    bus0.m_ready = 0; bus0.m_rdata = 0;
    bus0.d_valid = 1; bus0.d_addr = 32'hC000;                   // same cycle as d_ready
    tests_run++;
    if (bus0.d_ready !== 1'b1) begin
      failed++; $display("FAIL ovf_first_done: d_ready=%b, want 1", bus0.d_ready);
    end
    tick();                                                     // r+2
    bus0.d_valid = 0; bus0.d_addr = 0;
    tests_run++;
    if ({bus0.d_ovf, bus0.m_valid} !== 2'b00) begin
      failed++; $display("FAIL ovf_dropped_gone: got d_ovf=%b m_valid=%b, want 0 0", bus0.d_ovf, bus0.m_valid);
    end
    tick();                                                     // r+3
    tests_run++;
    if ({bus0.m_valid, bus0.m_addr, bus0.d_ovf} !== {1'b1, 32'hC000, 1'b0}) begin
      failed++; $display("FAIL ovf_same_cycle_accept: got m_valid=%b m_addr=%h d_ovf=%b, want 1 0000c000 0",
                         bus0.m_valid, bus0.m_addr, bus0.d_ovf);
    end
    tick();
    bus0.m_ready = 1; tick();
    bus0.m_ready = 0; tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    bus0.i_valid = 1; bus0.i_addr = 32'h40; tick();
    bus0.i_valid = 0; tick();                                   // m_valid
    tick();                                                     // BUSY, fetch owns
    bus0.d_valid = 1; bus0.d_addr = 32'h80; tick();             // data captured while busy
    bus0.d_valid = 0; reset = 1; tick();
    reset = 0;
    tests_run++;
    if ({bus0.m_valid, bus0.m_instr, bus0.m_addr, bus0.m_wdata, bus0.m_wstrb, bus0.i_ready,
         bus0.i_rdata, bus0.d_ready, bus0.d_rdata, bus0.i_ovf, bus0.d_ovf} !== 138'd0) begin
      failed++; $display("FAIL midreset_outputs: got m_valid=%b m_instr=%b m_addr=%h, want all 0",
                         bus0.m_valid, bus0.m_instr, bus0.m_addr);
    end
    for (int k = 0; k < 4; k++) begin
      tick();
      tests_run++;
      if (bus0.m_valid !== 1'b0) begin
        failed++; $display("FAIL midreset_slot_cleared cyc%0d: m_valid=%b, want 0", k, bus0.m_valid);
      end
    end
    bus0.m_ready = 1; bus0.m_rdata = 32'h99; tick();
    bus0.m_ready = 0; bus0.m_rdata = 0;
    tests_run++;
    if ({bus0.i_ready, bus0.d_ready} !== 2'b00) begin
      failed++; $display("FAIL midreset_no_response: got i_ready=%b d_ready=%b, want 0 0", bus0.i_ready, bus0.d_ready);
    end
    tick();
  endtask

  // Randomised traffic on the round-robin instance against a reference model
  // that tracks per-port pending requests and the single outstanding owner.
  task automatic test_random();
    bit          pend [2];
    logic [31:0] pa [2], pw [2];
    logic [3:0]  ps [2];
    bit          busy;
    int          owner, last, win;
    logic        e_mv, e_mi;
    logic [31:0] e_ma, e_mw;
    logic [3:0]  e_ms;
    logic        e_rdy [2];
    logic [31:0] e_rd [2];
    logic        e_ovf [2];
    bit          v [2], cap [2];
    logic [31:0] va [2], vw [2];
    logic [3:0]  vs [2];
    bit          mr;
    logic [31:0] mrd;
    do_reset();
    busy = 0; owner = 0; last = 1;
    e_mv = 0; e_mi = 0; e_ma = 0; e_mw = 0; e_ms = 0;
    for (int p = 0; p < 2; p++) begin
      pend[p] = 0; pa[p] = 0; pw[p] = 0; ps[p] = 0; e_rdy[p] = 0; e_rd[p] = 0; e_ovf[p] = 0;
    end
    for (int cyc = 0; cyc < 600; cyc++) begin
      tests_run++;
      if ({bus0.m_valid, bus0.m_instr, bus0.m_addr, bus0.m_wdata, bus0.m_wstrb, bus0.i_ready, bus0.i_rdata,
           bus0.d_ready, bus0.d_rdata, bus0.i_ovf, bus0.d_ovf} !==
          {e_mv, e_mi, e_ma, e_mw, e_ms, e_rdy[0], e_rd[0], e_rdy[1], e_rd[1], e_ovf[0], e_ovf[1]}) begin
        failed++;
        $display("FAIL random cyc%0d: got mv=%b mi=%b ma=%h mw=%h ms=%h ir=%b id=%h dr=%b dd=%h io=%b do=%b, want mv=%b mi=%b ma=%h mw=%h ms=%h ir=%b id=%h dr=%b dd=%h io=%b do=%b",
                 cyc, bus0.m_valid, bus0.m_instr, bus0.m_addr, bus0.m_wdata, bus0.m_wstrb, bus0.i_ready, bus0.i_rdata,
                 bus0.d_ready, bus0.d_rdata, bus0.i_ovf, bus0.d_ovf,
                 e_mv, e_mi, e_ma, e_mw, e_ms, e_rdy[0], e_rd[0], e_rdy[1], e_rd[1], e_ovf[0], e_ovf[1]);
      end
      for (int p = 0; p < 2; p++) begin
        v[p]  = ($urandom_range(0, 3) == 0);
        va[p] = $urandom;
        vw[p] = (p == 1) ? $urandom : 32'h0;
        vs[p] = (p == 1 && $urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0;
      end
      mr  = busy ? (!e_mv && $urandom_range(0, 2) == 0) : ($urandom_range(0, 15) == 0);
      mrd = $urandom;
      bus0.i_valid = v[0]; bus0.i_addr = va[0];
      bus0.d_valid = v[1]; bus0.d_addr = va[1]; bus0.d_wdata = vw[1]; bus0.d_wstrb = vs[1];
      bus0.m_ready = mr;   bus0.m_rdata = mrd;

      e_mv = 0;
      for (int p = 0; p < 2; p++) begin
        e_rdy[p] = 0; e_rd[p] = 0; e_ovf[p] = 0; cap[p] = 0;
        if (v[p]) begin
          if (pend[p] || (busy && owner == p)) e_ovf[p] = 1;
          else                                 cap[p] = 1;
        end
      end
      if (!busy) begin
        if (pend[0] || pend[1]) begin
          win  = (pend[0] && pend[1]) ? (1 - last) : (pend[1] ? 1 : 0);
          e_mv = 1; e_mi = (win == 0); e_ma = pa[win]; e_mw = pw[win]; e_ms = ps[win];
          last = win; busy = 1; owner = win; pend[win] = 0;
        end
      end else if (mr) begin
        e_rdy[owner] = 1; e_rd[owner] = mrd; busy = 0;
      end
      for (int p = 0; p < 2; p++) begin
        if (cap[p]) begin
          pend[p] = 1; pa[p] = va[p]; pw[p] = vw[p]; ps[p] = vs[p];
        end
      end
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_single_fetch();
    test_data_store();
    test_round_robin();
    test_fixed_prio();
    test_overflow();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, tests_run=%0d", tests_run);
    $fatal(1, "watchdog");
  end
endmodule
